// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two valid/ready requesters.
// Each port has a registered result buffer. A port is never granted while its buffer holds an unread result.
module alu_share_arbiter #(
  parameter int              DATA_W  = 32,
  parameter int              OP_W    = 4,
  parameter logic [OP_W-1:0] IDLE_OP = {OP_W{1'b0}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [OP_W-1:0]   req0_op_i,
  input  logic [DATA_W-1:0] req0_a_i,
  input  logic [DATA_W-1:0] req0_b_i,
  output logic              rsp0_valid_o,
  input  logic              rsp0_ready_i,
  output logic [DATA_W-1:0] rsp0_result_o,
  output logic              rsp0_zero_o,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [OP_W-1:0]   req1_op_i,
  input  logic [DATA_W-1:0] req1_a_i,
  input  logic [DATA_W-1:0] req1_b_i,
  output logic              rsp1_valid_o,
  input  logic              rsp1_ready_i,
  output logic [DATA_W-1:0] rsp1_result_o,
  output logic              rsp1_zero_o,
  output logic [OP_W-1:0]   alu_op_o,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic              alu_zero_i
);

  logic              elig0_s;
  logic              elig1_s;
  logic              grant0_s;
  logic              grant1_s;
  logic              last_grant_r;
  logic              rsp0_valid_r;
  logic              rsp1_valid_r;
  logic [DATA_W-1:0] rsp0_result_r;
  logic [DATA_W-1:0] rsp1_result_r;
  logic              rsp0_zero_r;
  logic              rsp1_zero_r;

  // A port can be served when its buffer is empty or is being drained this cycle.
  assign elig0_s = req0_valid_i & (~rsp0_valid_r | rsp0_ready_i);
  assign elig1_s = req1_valid_i & (~rsp1_valid_r | rsp1_ready_i);

  // Round-robin grant: on a tie, the port that was not granted last time wins.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (reset) begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end else if (elig0_s && elig1_s) begin
      grant0_s = last_grant_r;
      grant1_s = ~last_grant_r;
    end else if (elig0_s) begin
      grant0_s = 1'b1;
    end else if (elig1_s) begin
      grant1_s = 1'b1;
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  assign req0_ready_o = grant0_s;
  assign req1_ready_o = grant1_s;

  // Route the granted port's operation to the ALU. When no port is granted, drive a quiet idle op.
  always_comb begin
    alu_op_o = IDLE_OP;
    alu_a_o  = {DATA_W{1'b0}};
    alu_b_o  = {DATA_W{1'b0}};
    case ({grant1_s, grant0_s})
      2'b01: begin
        alu_op_o = req0_op_i;
        alu_a_o  = req0_a_i;
        alu_b_o  = req0_b_i;
      end
      2'b10: begin
        alu_op_o = req1_op_i;
        alu_a_o  = req1_a_i;
        alu_b_o  = req1_b_i;
      end
      default: begin
        alu_op_o = IDLE_OP;
        alu_a_o  = {DATA_W{1'b0}};
        alu_b_o  = {DATA_W{1'b0}};
      end
    endcase
  end

  // Remember the last granted port. Idle cycles leave it unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_r <= 1'b1;
    end else if (grant0_s) begin
      last_grant_r <= 1'b0;
    end else if (grant1_s) begin
      last_grant_r <= 1'b1;
    end
  end

  // Port 0 response buffer. A new capture wins over a drain in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp0_valid_r  <= 1'b0;
      rsp0_result_r <= {DATA_W{1'b0}};
      rsp0_zero_r   <= 1'b0;
    end else if (grant0_s) begin
      rsp0_valid_r  <= 1'b1;
      rsp0_result_r <= alu_result_i;
      rsp0_zero_r   <= alu_zero_i;
    end else if (rsp0_ready_i) begin
      rsp0_valid_r  <= 1'b0;
    end
  end

  // Port 1 response buffer, mirroring port 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp1_valid_r  <= 1'b0;
      rsp1_result_r <= {DATA_W{1'b0}};
      rsp1_zero_r   <= 1'b0;
    end else if (grant1_s) begin
      rsp1_valid_r  <= 1'b1;
      rsp1_result_r <= alu_result_i;
      rsp1_zero_r   <= alu_zero_i;
    end else if (rsp1_ready_i) begin
      rsp1_valid_r  <= 1'b0;
    end
  end

  assign rsp0_valid_o  = rsp0_valid_r;
  assign rsp0_result_o = rsp0_result_r;
  assign rsp0_zero_o   = rsp0_zero_r;
  assign rsp1_valid_o  = rsp1_valid_r;
  assign rsp1_result_o = rsp1_result_r;
  assign rsp1_zero_o   = rsp1_zero_r;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small behavioural ALU attached.
// Inputs change on the falling edge and outputs are checked away from the rising edge.
module tb_alu_share_arbiter;

  logic        clk;
  logic        reset;
  logic        req0_valid_i, req1_valid_i;
  logic        req0_ready_o, req1_ready_o;
  logic [3:0]  req0_op_i, req1_op_i;
  logic [31:0] req0_a_i, req0_b_i, req1_a_i, req1_b_i;
  logic        rsp0_valid_o, rsp1_valid_o;
  logic        rsp0_ready_i, rsp1_ready_i;
  logic [31:0] rsp0_result_o, rsp1_result_o;
  logic        rsp0_zero_o, rsp1_zero_o;
  logic [3:0]  alu_op_o;
  logic [31:0] alu_a_o, alu_b_o;
  logic [31:0] alu_result_i;
  logic        alu_zero_i;

  int total = 0;
  int bad   = 0;

  alu_share_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_op_i(req0_op_i),
    .req0_a_i(req0_a_i), .req0_b_i(req0_b_i),
    .rsp0_valid_o(rsp0_valid_o), .rsp0_ready_i(rsp0_ready_i),
    .rsp0_result_o(rsp0_result_o), .rsp0_zero_o(rsp0_zero_o),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_op_i(req1_op_i),
    .req1_a_i(req1_a_i), .req1_b_i(req1_b_i),
    .rsp1_valid_o(rsp1_valid_o), .rsp1_ready_i(rsp1_ready_i),
    .rsp1_result_o(rsp1_result_o), .rsp1_zero_o(rsp1_zero_o),
    .alu_op_o(alu_op_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
    .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  always_comb begin
    case (alu_op_o)
      4'd0:    alu_result_i = alu_a_o + alu_b_o;
      4'd1:    alu_result_i = alu_a_o - alu_b_o;
      4'd2:    alu_result_i = alu_a_o & alu_b_o;
      4'd3:    alu_result_i = alu_a_o | alu_b_o;
      4'd4:    alu_result_i = alu_a_o ^ alu_b_o;
      default: alu_result_i = 32'd0;
    endcase
    alu_zero_i = (alu_result_i == 32'd0);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_req0(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req0_valid_i = v; req0_op_i = op; req0_a_i = a; req0_b_i = b;
  endtask

  task automatic set_req1(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req1_valid_i = v; req1_op_i = op; req1_a_i = a; req1_b_i = b;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    set_req0(1'b0, 4'd0, 32'd0, 32'd0);
    set_req1(1'b0, 4'd0, 32'd0, 32'd0);
    rsp0_ready_i = 1'b1;
    rsp1_ready_i = 1'b1;
    @(negedge clk);
    chk("rst_rsp0_valid", {31'd0, rsp0_valid_o}, 32'd0);
    chk("rst_rsp1_valid", {31'd0, rsp1_valid_o}, 32'd0);
    chk("rst_rsp0_result", rsp0_result_o, 32'd0);
    chk("rst_rsp1_zero", {31'd0, rsp1_zero_o}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Single ADD on port 0.
    set_req0(1'b1, 4'd0, 32'd5, 32'd7);
    #1;
    chk("add_req0_ready", {31'd0, req0_ready_o}, 32'd1);
    chk("add_req1_ready", {31'd0, req1_ready_o}, 32'd0);
    chk("add_alu_op", {28'd0, alu_op_o}, 32'd0);
    chk("add_alu_a", alu_a_o, 32'd5);
    chk("add_alu_b", alu_b_o, 32'd7);
    @(negedge clk);
    set_req0(1'b0, 4'd0, 32'd0, 32'd0);
    chk("add_rsp0_valid", {31'd0, rsp0_valid_o}, 32'd1);
    chk("add_rsp0_result", rsp0_result_o, 32'd12);
    chk("add_rsp0_zero", {31'd0, rsp0_zero_o}, 32'd0);

    // First tie after reset goes to port 0, then port 1.
    do_reset();
    set_req0(1'b1, 4'd1, 32'd9, 32'd9);
    set_req1(1'b1, 4'd3, 32'h0000_00F0, 32'h0000_000F);
    #1;
    chk("tie_req0_ready", {31'd0, req0_ready_o}, 32'd1);
    chk("tie_req1_ready", {31'd0, req1_ready_o}, 32'd0);
    @(negedge clk);
    set_req0(1'b0, 4'd0, 32'd0, 32'd0);
    chk("sub_rsp0_result", rsp0_result_o, 32'd0);
    chk("sub_rsp0_zero", {31'd0, rsp0_zero_o}, 32'd1);
    chk("sub_rsp0_valid", {31'd0, rsp0_valid_o}, 32'd1);
    #1;
    chk("or_req1_ready", {31'd0, req1_ready_o}, 32'd1);
    @(negedge clk);
    set_req1(1'b0, 4'd0, 32'd0, 32'd0);
    chk("or_rsp1_result", rsp1_result_o, 32'h0000_00FF);
    chk("or_rsp1_zero", {31'd0, rsp1_zero_o}, 32'd0);
    chk("drain_rsp0_valid", {31'd0, rsp0_valid_o}, 32'd0);

    // Both continuously valid: strict alternation starting with port 0.
    set_req0(1'b1, 4'd2, 32'hFF00, 32'h0FF0);
    set_req1(1'b1, 4'd4, 32'h1234, 32'h1234);
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rr_req0_ready", {31'd0, req0_ready_o}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_req1_ready", {31'd0, req1_ready_o}, (i % 2 == 0) ? 32'd0 : 32'd1);
      chk("rr_alu_op", {28'd0, alu_op_o}, (i % 2 == 0) ? 32'd2 : 32'd4);
      @(negedge clk);
    end
    chk("rr_rsp1_result", rsp1_result_o, 32'd0);
    chk("rr_rsp0_result", rsp0_result_o, 32'h0F00);

    // Back-pressure on port 0 blocks it while port 1 proceeds.
    set_req1(1'b0, 4'd0, 32'd0, 32'd0);
    set_req0(1'b1, 4'd0, 32'd1, 32'd2);
    @(negedge clk);
    chk("bp_rsp0_first", rsp0_result_o, 32'd3);
    rsp0_ready_i = 1'b0;
    set_req0(1'b1, 4'd0, 32'd10, 32'd20);
    set_req1(1'b1, 4'd1, 32'd50, 32'd8);
    #1;
    chk("bp_req0_ready", {31'd0, req0_ready_o}, 32'd0);
    chk("bp_req1_ready", {31'd0, req1_ready_o}, 32'd1);
    @(negedge clk);
    set_req1(1'b0, 4'd0, 32'd0, 32'd0);
    chk("bp_rsp0_hold", rsp0_result_o, 32'd3);
    chk("bp_rsp0_valid", {31'd0, rsp0_valid_o}, 32'd1);
    chk("bp_rsp1_result", rsp1_result_o, 32'd42);
    rsp0_ready_i = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, req0_ready_o}, 32'd1);
    @(negedge clk);
    set_req0(1'b0, 4'd0, 32'd0, 32'd0);
    chk("bp_rsp0_new", rsp0_result_o, 32'd30);
    chk("bp_rsp0_valid2", {31'd0, rsp0_valid_o}, 32'd1);

    // Idle cycles: idle ALU drive, and last_grant (port 0) is kept.
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("idle_alu_op", {28'd0, alu_op_o}, 32'd0);
      chk("idle_alu_a", alu_a_o, 32'd0);
      chk("idle_alu_b", alu_b_o, 32'd0);
      @(negedge clk);
    end
    set_req0(1'b1, 4'd0, 32'd3, 32'd4);
    set_req1(1'b1, 4'd0, 32'd6, 32'd7);
    #1;
    chk("idle_tie_req1", {31'd0, req1_ready_o}, 32'd1);
    chk("idle_tie_req0", {31'd0, req0_ready_o}, 32'd0);
    @(negedge clk);
    set_req1(1'b0, 4'd0, 32'd0, 32'd0);
    set_req0(1'b0, 4'd0, 32'd0, 32'd0);
    rsp1_ready_i = 1'b0;
    chk("pre_rst_rsp1_valid", {31'd0, rsp1_valid_o}, 32'd1);
    chk("pre_rst_rsp1_result", rsp1_result_o, 32'd13);

    // Asynchronous reset between edges, with a request held during reset.
    #2;
    reset = 1'b1;
    set_req0(1'b1, 4'd0, 32'd1, 32'd1);
    #1;
    chk("arst_rsp1_valid", {31'd0, rsp1_valid_o}, 32'd0);
    chk("arst_rsp1_result", rsp1_result_o, 32'd0);
    chk("arst_req0_ready", {31'd0, req0_ready_o}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    rsp1_ready_i = 1'b1;
    set_req1(1'b1, 4'd0, 32'd2, 32'd2);
    #1;
    chk("post_rst_req0", {31'd0, req0_ready_o}, 32'd1);
    chk("post_rst_req1", {31'd0, req1_ready_o}, 32'd0);
    @(negedge clk);
    chk("post_rst_rsp0_result", rsp0_result_o, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
